snn_step_scheduler: RTL and testbench

SNN_STEP_SCHEDULER -- requirements
Module: snn_step_scheduler

---
 rtl/snn_sched_pkg.sv | 15 +
 rtl/spike_frame_fifo.sv | 61 ++++++
 rtl/snn_step_scheduler.sv | 143 ++++++++++++++
 tb/tb_snn_step_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared constants and FSM encoding for the SNN time-step scheduler.
package snn_sched_pkg;

  localparam int unsigned FRAME_W = 20;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned STEP_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_HOLD      = 2'd3
  } sched_state_t;

endpackage

// File: rtl/spike_frame_fifo.sv
// Circular queue of spike frames; head is visible combinationally.
module spike_frame_fifo #(
  parameter int unsigned FRAME_W = 20,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [FRAME_W-1:0]     push_data,
  input  logic                   pop,
  output logic [FRAME_W-1:0]     head_c,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full_c,
  output logic                   empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  // A push into a full queue is dropped even if a pop lands in the same cycle.
  assign full_c  = (level == LVL_W'(DEPTH));
  assign empty_c = (level == '0);
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;
  assign head_c  = mem[rd_ptr];

  // Frame storage; contents are meaningless while the level says empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// Queues SPI spike frames and hands one to the SNN on every divided-clock tick.
module snn_step_scheduler #(
  parameter int unsigned FRAME_W = snn_sched_pkg::FRAME_W,
  parameter int unsigned DEPTH   = snn_sched_pkg::DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              frame_valid,
  input  logic [FRAME_W-1:0]                frame_in,
  input  logic                              step_tick,
  input  logic                              run_en,
  input  logic                              clear_flags,
  output logic [FRAME_W-1:0]                snn_spikes,
  output logic                              snn_enable,
  output logic [snn_sched_pkg::STEP_W-1:0]  step_count,
  output logic [$clog2(DEPTH):0]            fifo_level,
  output logic                              overflow,
  output logic                              underflow
);

  import snn_sched_pkg::*;

  sched_state_t       state;
  logic               fv_sync;
  logic               fv_prev;
  logic               tick_sync;
  logic               tick_prev;
  logic               fv_rise;
  logic               tick_rise;
  logic               push_ok;
  logic               pop_req;
  logic               ovf_event;
  logic               udf_event;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] fifo_head;
  logic [FRAME_W-1:0] issue_frame;

  // Sync and previous-value registers for the two rising-edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv_sync   <= 1'b0;
      fv_prev   <= 1'b0;
      tick_sync <= 1'b0;
      tick_prev <= 1'b0;
    end else begin
      fv_sync   <= frame_valid;
      fv_prev   <= fv_sync;
      tick_sync <= step_tick;
      tick_prev <= tick_sync;
    end
  end

  assign fv_rise   = fv_sync & ~fv_prev;
  assign tick_rise = tick_sync & ~tick_prev;
  assign push_ok   = fv_rise & ~fifo_full;
  assign pop_req   = (state == ST_ISSUE);
  assign ovf_event = fv_rise & fifo_full;
  assign udf_event = (state == ST_ISSUE) & fifo_empty;

  spike_frame_fifo #(
    .FRAME_W (FRAME_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fv_rise),
    .push_data (frame_in),
    .pop       (pop_req),
    .head_c    (fifo_head),
    .level     (fifo_level),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  // Frame the ISSUE cycle will pop: a push landing on the ISSUE edge is what the queue holds then.
  always_comb begin
    issue_frame = '0;
    if (!fifo_empty) begin
      issue_frame = fifo_head;
    end else if (push_ok) begin
      issue_frame = frame_in;
    end
  end

  // Step FSM; enable, spikes and count are loaded on the edge that enters ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      snn_enable <= 1'b0;
      snn_spikes <= '0;
      step_count <= '0;
    end else begin
      snn_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run_en) begin
            state <= ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (!run_en) begin
            state <= ST_IDLE;
          end else if (tick_rise) begin
            state      <= ST_ISSUE;
            snn_enable <= 1'b1;
            snn_spikes <= issue_frame;
            step_count <= step_count + STEP_W'(1);
          end
        end
        ST_ISSUE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          state <= run_en ? ST_WAIT_TICK : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flags; a new event beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (udf_event) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Scenario bench for snn_step_scheduler with a frame-queue reference model.
module tb_snn_step_scheduler;

  localparam int unsigned FW = 20;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_valid;
  logic [FW-1:0] frame_in;
  logic          step_tick;
  logic          run_en;
  logic          clear_flags;
  logic [FW-1:0] snn_spikes;
  logic          snn_enable;
  logic [15:0]   step_count;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int            obs_cyc[$];
  logic [FW-1:0] obs_spk[$];

  snn_step_scheduler #(.FRAME_W(FW), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_in(frame_in),
    .step_tick(step_tick), .run_en(run_en), .clear_flags(clear_flags),
    .snn_spikes(snn_spikes), .snn_enable(snn_enable), .step_count(step_count),
    .fifo_level(fifo_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every enable pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (snn_enable === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_spk.push_back(snn_spikes);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_valid = 1'b0; step_tick = 1'b0;
    run_en = 1'b0; clear_flags = 1'b0; frame_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer one frame; optionally pulse clear_flags on the cycle the push is decided.
  task automatic push_frame(input logic [FW-1:0] f, input bit clr);
    @(negedge clk); frame_in = f; frame_valid = 1'b1;
    @(negedge clk); clear_flags = clr;
    @(negedge clk); frame_valid = 1'b0; clear_flags = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One step tick; returns pulse count, latency from tick rise and issued frame.
  task automatic do_tick(input bit clr, input bit drop_run,
                         output int pulses, output int lat, output logic [FW-1:0] spk);
    int n0, t;
    n0 = obs_cyc.size();
    @(negedge clk); step_tick = 1'b1; t = cyc;
    @(negedge clk); step_tick = 1'b0;
    @(negedge clk); clear_flags = clr; if (drop_run) run_en = 1'b0;
    @(negedge clk); clear_flags = 1'b0;
    repeat (3) @(negedge clk);
    pulses = obs_cyc.size() - n0;
    if (pulses > 0) begin lat = obs_cyc[n0] - t; spk = obs_spk[n0]; end
    else begin lat = -1; spk = 'x; end
  endtask

  // Tick, then offer a frame whose push is decided in the ISSUE cycle.
  task automatic push_during_issue(input logic [FW-1:0] f, output int pulses,
                                   output logic [FW-1:0] spk);
    int n0;
    n0 = obs_cyc.size();
    @(negedge clk); step_tick = 1'b1;
    @(negedge clk); step_tick = 1'b0; frame_in = f; frame_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); frame_valid = 1'b0;
    repeat (4) @(negedge clk);
    pulses = obs_cyc.size() - n0;
    spk = (pulses > 0) ? obs_spk[n0] : 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_valid = 1'b0; step_tick = 1'b0;
    run_en = 1'b1; clear_flags = 1'b0; frame_in = 20'hABCDE;
    repeat (2) @(negedge clk);
    frame_valid = 1'b1; step_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_valid = 1'b0; step_tick = 1'b0; run_en = 1'b0;
    checks++; if (snn_spikes !== '0) begin errors++; $display("FAIL reset_spikes: got %0h want 0", snn_spikes); end
    checks++; if (snn_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0b want 0", snn_enable); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0h want 0", step_count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %0b want 0", underflow); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_push();
    int p, l; logic [FW-1:0] s;
    do_reset();
    for (int i = 0; i < 3; i++) push_frame(FW'($urandom), 1'b0);
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL idle_level: got %0d want 3", fifo_level); end
    checks++; if (p !== 0) begin errors++; $display("FAIL idle_no_pulse: got %0d pulses want 0", p); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL idle_count: got %0h want 0", step_count); end
  endtask

  task automatic test_order();
    int p, l; logic [FW-1:0] s; logic [FW-1:0] want;
    do_reset();
    push_frame(20'h00001, 1'b0);
    push_frame(20'h00002, 1'b0);
    push_frame(20'h00003, 1'b0);
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      want = FW'(i);
      do_tick(1'b0, 1'b0, p, l, s);
      checks++; if (p !== 1) begin errors++; $display("FAIL order_pulses[%0d]: got %0d want 1", i, p); end
      checks++; if (l !== 2) begin errors++; $display("FAIL order_latency[%0d]: got %0d want 2", i, l); end
      checks++; if (s !== want) begin errors++; $display("FAIL order_frame[%0d]: got %0h want %0h", i, s, want); end
      checks++; if (snn_spikes !== want) begin errors++; $display("FAIL order_hold[%0d]: got %0h want %0h", i, snn_spikes, want); end
    end
    checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL order_count: got %0h want 3", step_count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL order_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_overflow();
    int p, l; logic [FW-1:0] s; logic [FW-1:0] f [6];
    do_reset();
    for (int i = 0; i < 6; i++) f[i] = FW'($urandom_range(1, 20'hFFFFF));
    for (int i = 0; i < 4; i++) push_frame(f[i], 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %0b want 0", overflow); end
    push_frame(f[4], 1'b0);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    push_frame(f[5], 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b want 1", overflow); end
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0, 1'b0, p, l, s);
      checks++;
      if (s !== ((i < 4) ? f[i] : '0)) begin
        errors++; $display("FAIL ovf_issue[%0d]: got %0h want %0h", i, s, (i < 4) ? f[i] : '0);
      end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL ovf_tail_underflow: got %0b want 1", underflow); end
  endtask

  task automatic test_underflow();
    int p, l; logic [FW-1:0] s; logic [FW-1:0] f;
    do_reset();
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (s !== '0) begin errors++; $display("FAIL udf_frame: got %0h want 0", s); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set: got %0b want 1", underflow); end
    checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL udf_count: got %0h want 1", step_count); end
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %0b want 0", underflow); end
    do_tick(1'b1, 1'b0, p, l, s);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set_wins: got %0b want 1", underflow); end
    f = FW'($urandom_range(1, 20'hFFFFF));
    push_frame(f, 1'b0);
    do_tick(1'b0, 1'b1, p, l, s);
    checks++; if (p !== 1 || s !== f) begin errors++; $display("FAIL run_drop_issue: got %0d pulses frame %0h want 1 pulse frame %0h", p, s, f); end
    checks++; if (step_count !== 16'd3) begin errors++; $display("FAIL run_drop_count: got %0h want 3", step_count); end
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (p !== 0) begin errors++; $display("FAIL run_off_tick: got %0d pulses want 0", p); end
  endtask

  task automatic test_simultaneous();
    int p, l; logic [FW-1:0] s; logic [FW-1:0] a, b, c, d;
    do_reset();
    a = FW'($urandom_range(1, 20'hFFFFF)); b = FW'($urandom_range(1, 20'hFFFFF));
    c = FW'($urandom_range(1, 20'hFFFFF)); d = FW'($urandom_range(1, 20'hFFFFF));
    push_frame(a, 1'b0);
    push_frame(b, 1'b0);
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    push_during_issue(c, p, s);
    checks++; if (s !== a) begin errors++; $display("FAIL sim_old_head: got %0h want %0h", s, a); end
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL sim_level: got %0d want 2", fifo_level); end
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (s !== b) begin errors++; $display("FAIL sim_next_b: got %0h want %0h", s, b); end
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (s !== c) begin errors++; $display("FAIL sim_next_c: got %0h want %0h", s, c); end
    push_during_issue(d, p, s);
    checks++; if (p !== 1 || s !== '0) begin errors++; $display("FAIL sim_no_bypass: got %0d pulses frame %0h want 1 pulse frame 0", p, s); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL sim_empty_level: got %0d want 1", fifo_level); end
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (s !== d) begin errors++; $display("FAIL sim_queued_d: got %0h want %0h", s, d); end
  endtask

  task automatic test_random();
    int p, l; logic [FW-1:0] s; logic [FW-1:0] f; logic [FW-1:0] want;
    logic [FW-1:0] mq[$];
    logic exp_ovf, exp_uf;
    int exp_cnt;
    do_reset();
    exp_ovf = 1'b0; exp_uf = 1'b0; exp_cnt = 0; want = '0;
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 99) < 55) begin
        f = FW'($urandom);
        push_frame(f, 1'b0);
        if (mq.size() == DP) exp_ovf = 1'b1;
        else mq.push_back(f);
      end else begin
        do_tick(1'b0, 1'b0, p, l, s);
        if (mq.size() > 0) want = mq.pop_front();
        else begin want = '0; exp_uf = 1'b1; end
        exp_cnt++;
        checks++; if (p !== 1 || l !== 2) begin errors++; $display("FAIL rnd_pulse[%0d]: got %0d pulses latency %0d want 1 and 2", i, p, l); end
        checks++; if (s !== want) begin errors++; $display("FAIL rnd_frame[%0d]: got %0h want %0h", i, s, want); end
      end
    end
    checks++; if (fifo_level !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level: got %0d want %0d", fifo_level, mq.size()); end
    checks++; if (step_count !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_count: got %0h want %0h", step_count, exp_cnt); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd_overflow: got %0b want %0b", overflow, exp_ovf); end
    checks++; if (underflow !== exp_uf) begin errors++; $display("FAIL rnd_underflow: got %0b want %0b", underflow, exp_uf); end
    checks++; if (snn_spikes !== want) begin errors++; $display("FAIL rnd_hold: got %0h want %0h", snn_spikes, want); end
  endtask

  task automatic test_wrap_reset();
    int p, l; logic [FW-1:0] s; logic [FW-1:0] f;
    logic [15:0] want_cnt [3];
    want_cnt[0] = 16'hFFFE; want_cnt[1] = 16'hFFFF; want_cnt[2] = 16'h0000;
    do_reset();
    run_en = 1'b1;
    repeat (2) @(negedge clk);
    force dut.step_count = 16'hFFFD;
    @(negedge clk);
    release dut.step_count;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b0, 1'b0, p, l, s);
      checks++; if (step_count !== want_cnt[i]) begin errors++; $display("FAIL wrap_count[%0d]: got %0h want %0h", i, step_count, want_cnt[i]); end
    end
    for (int i = 0; i < 5; i++) push_frame(FW'($urandom_range(1, 20'hFFFFF)), 1'b0);
    @(negedge clk); step_tick = 1'b1;
    @(negedge clk); step_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (snn_spikes !== '0) begin errors++; $display("FAIL rst_mid_spikes: got %0h want 0", snn_spikes); end
    checks++; if (snn_enable !== 1'b0) begin errors++; $display("FAIL rst_mid_enable: got %0b want 0", snn_enable); end
    checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count: got %0h want 0", step_count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %0b%0b want 00", overflow, underflow); end
    @(negedge clk); rst_n = 1'b1;
    f = FW'($urandom_range(1, 20'hFFFFF));
    push_frame(f, 1'b0);
    do_tick(1'b0, 1'b0, p, l, s);
    checks++; if (p !== 1 || s !== f) begin errors++; $display("FAIL rst_resume: got %0d pulses frame %0h want 1 pulse frame %0h", p, s, f); end
    checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL rst_resume_count: got %0h want 1", step_count); end
  endtask

  initial begin
    test_reset();
    test_idle_push();
    test_order();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_random();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
